// File: rtl/pllMap_pkg.sv
// Shared types and widths for the PLL status read path back to the register map.
package pllMap_pkg;

   localparam int unsigned PllLockCntW = 16;
   localparam int unsigned PllLossCntW = 8;
   localparam int unsigned PllDebCntW  = 4;

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } pll_state_e;

   typedef struct packed {
      logic [1:0]             state;
      logic                   locked;
      logic                   lock_lost;
      logic                   lock_timeout;
      logic [PllLockCntW-1:0] lock_cycles;
      logic [PllLossCntW-1:0] loss_count;
   } pll2pllmap;

   // Increment that sticks at all-ones.
   function automatic logic [PllLossCntW-1:0] sat_inc_loss(input logic [PllLossCntW-1:0] v);
      return (v == '1) ? v : PllLossCntW'(v + 1'b1);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the raw PLL lock plus the acquisition debounce counter.
module pll_lock_sync
   import pllMap_pkg::*;
#(
   parameter int unsigned DebounceCycles = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pll_lock_i,
   input  logic acquire_i,
   output logic lock_s,
   output logic deb_done
);

   logic                  sync1_q, sync1_d;
   logic                  lock_s_q, lock_s_d;
   logic [PllDebCntW-1:0] deb_cnt_q, deb_cnt_d;

   always_comb begin
      sync1_d   = pll_lock_i;
      lock_s_d  = sync1_q;
      deb_cnt_d = '0;
      if (acquire_i && lock_s_q) begin
         deb_cnt_d = (deb_cnt_q == '1) ? deb_cnt_q : PllDebCntW'(deb_cnt_q + 1'b1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b0;
         lock_s_q  <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         lock_s_q  <= lock_s_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   assign lock_s   = lock_s_q;
   // This edge is the last of the required run of synchronised-high cycles.
   assign deb_done = lock_s_q && (deb_cnt_q == PllDebCntW'(DebounceCycles - 1));

endmodule

// File: rtl/pll_status_monitor.sv
// PLL lock supervision FSM, sticky flags, counters and snapshot read port.
module pll_status_monitor
   import pllMap_pkg::*;
#(
   parameter int unsigned LockTimeout    = 50000,
   parameter int unsigned DebounceCycles = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      pllen_i,
   input  logic      pll_lock_i,
   input  logic      rd_req_i,
   input  logic      clr_i,
   output logic      rd_valid_o,
   output pll2pllmap status_o
);

   pll_state_e             state_q, state_d;
   logic [PllLockCntW-1:0] acq_cnt_q, acq_cnt_d;
   logic [PllLockCntW-1:0] lock_cycles_q, lock_cycles_d;
   logic                   lock_lost_q, lock_lost_d;
   logic                   lock_timeout_q, lock_timeout_d;
   logic [PllLossCntW-1:0] loss_count_q, loss_count_d;
   logic                   rd_valid_q, rd_valid_d;
   pll2pllmap              status_q, status_d;
   logic                   lock_s;
   logic                   deb_done;
   logic                   loss_evt;

   pll_lock_sync #(
      .DebounceCycles(DebounceCycles)
   ) u_lock_sync (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pll_lock_i(pll_lock_i),
      .acquire_i (state_q == ACQUIRE),
      .lock_s    (lock_s),
      .deb_done  (deb_done)
   );

   always_comb begin
      state_d        = state_q;
      acq_cnt_d      = acq_cnt_q;
      lock_cycles_d  = lock_cycles_q;
      lock_lost_d    = lock_lost_q;
      lock_timeout_d = lock_timeout_q;
      loss_count_d   = loss_count_q;
      rd_valid_d     = rd_req_i;
      status_d       = status_q;
      loss_evt       = 1'b0;

      if (!pllen_i) begin
         state_d = OFF;
      end else begin
         unique case (state_q)
            OFF:     state_d = ACQUIRE;
            ACQUIRE: if (deb_done) begin
               state_d       = LOCKED;
               lock_cycles_d = acq_cnt_q;
            end
            LOCKED:  if (!lock_s) begin
               state_d  = LOST;
               loss_evt = 1'b1;
            end
            LOST:    state_d = ACQUIRE;
            default: state_d = OFF;
         endcase
      end

      if (state_q == ACQUIRE && acq_cnt_q != '1) begin
         acq_cnt_d = PllLockCntW'(acq_cnt_q + 1'b1);
      end
      if (state_d == ACQUIRE && state_q != ACQUIRE) begin
         acq_cnt_d = '0;
      end

      // Clear first so a coincident set event wins.
      if (clr_i) begin
         lock_lost_d    = 1'b0;
         lock_timeout_d = 1'b0;
         loss_count_d   = '0;
      end
      if (loss_evt) begin
         lock_lost_d  = 1'b1;
         loss_count_d = sat_inc_loss(loss_count_d);
      end
      if (state_q == ACQUIRE && acq_cnt_q == PllLockCntW'(LockTimeout - 1)) begin
         lock_timeout_d = 1'b1;
      end

      if (rd_req_i) begin
         status_d.state        = state_d;
         status_d.locked       = (state_d == LOCKED);
         status_d.lock_lost    = lock_lost_d;
         status_d.lock_timeout = lock_timeout_d;
         status_d.lock_cycles  = lock_cycles_d;
         status_d.loss_count   = loss_count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= OFF;
         acq_cnt_q      <= '0;
         lock_cycles_q  <= '0;
         lock_lost_q    <= 1'b0;
         lock_timeout_q <= 1'b0;
         loss_count_q   <= '0;
         rd_valid_q     <= 1'b0;
         status_q       <= '0;
      end else begin
         state_q        <= state_d;
         acq_cnt_q      <= acq_cnt_d;
         lock_cycles_q  <= lock_cycles_d;
         lock_lost_q    <= lock_lost_d;
         lock_timeout_q <= lock_timeout_d;
         loss_count_q   <= loss_count_d;
         rd_valid_q     <= rd_valid_d;
         status_q       <= status_d;
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign status_o   = status_q;

endmodule

// File: tb/tb_pll_status_monitor.sv
// Self-checking bench for pll_status_monitor: directed scenarios plus random traffic vs a cycle model.
module tb_pll_status_monitor;
   import pllMap_pkg::*;

   localparam int unsigned TO  = 100;
   localparam int unsigned DEB = 4;

   logic      clk = 1'b0;
   logic      rst, pllen, lock, rd, clr;
   logic      rd_valid;
   pll2pllmap status;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (plain integers)
   int        m_sync1, m_lock_s, m_run, m_state, m_acq, m_lock_cycles;
   int        m_lost, m_to, m_loss, m_next;
   logic      exp_valid;
   pll2pllmap exp_status;

   pll_status_monitor #(
      .LockTimeout   (TO),
      .DebounceCycles(DEB)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .pllen_i   (pllen),
      .pll_lock_i(lock),
      .rd_req_i  (rd),
      .clr_i     (clr),
      .rd_valid_o(rd_valid),
      .status_o  (status)
   );

   always #5 clk = ~clk;

   // One clock of the behavioural model, evaluated with the inputs seen at the edge.
   task automatic model_update();
      if (rst) begin
         m_sync1 = 0; m_lock_s = 0; m_run = 0; m_state = 0; m_acq = 0;
         m_lock_cycles = 0; m_lost = 0; m_to = 0; m_loss = 0;
         exp_valid = 1'b0; exp_status = '0;
      end else begin
         m_run = (m_state == 1 && m_lock_s == 1) ? m_run + 1 : 0;
         if (!pllen)            m_next = 0;
         else if (m_state == 0) m_next = 1;
         else if (m_state == 1) m_next = (m_lock_s == 1 && m_run == DEB) ? 2 : 1;
         else if (m_state == 2) m_next = (m_lock_s == 1) ? 2 : 3;
         else                   m_next = 1;
         if (m_state == 1 && m_next == 2) m_lock_cycles = m_acq;
         if (clr) begin m_lost = 0; m_to = 0; m_loss = 0; end
         if (m_state == 2 && m_next == 3) begin
            m_lost = 1;
            if (m_loss < 255) m_loss = m_loss + 1;
         end
         if (m_state == 1 && m_acq == TO - 1) m_to = 1;
         if (m_state != 1 && m_next == 1) m_acq = 0;
         else if (m_state == 1 && m_acq < 65535) m_acq = m_acq + 1;
         m_lock_s = m_sync1;
         m_sync1  = lock ? 1 : 0;
         m_state  = m_next;
         exp_valid = rd;
         if (rd) begin
            exp_status.state        = 2'(m_state);
            exp_status.locked       = (m_state == 2);
            exp_status.lock_lost    = (m_lost != 0);
            exp_status.lock_timeout = (m_to != 0);
            exp_status.lock_cycles  = 16'(m_lock_cycles);
            exp_status.loss_count   = 8'(m_loss);
         end
      end
   endtask

   task automatic drive(input logic r, input logic pe, input logic lk, input logic rq, input logic cl);
      rst = r; pllen = pe; lock = lk; rd = rq; clr = cl;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      step();
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got=%b want=0", rd_valid);
      end
      n_checks++;
      if (status !== '0) begin
         n_fail++; $display("FAIL reset_status got=%h want=0", status);
      end
   endtask

   task automatic test_lock();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int e = 1; e <= 18; e++) begin
         drive(1'b0, e >= 2, e >= 12, 1'b1, 1'b0);
         step();
         n_checks++;
         if ({rd_valid, status} !== {exp_valid, exp_status}) begin
            n_fail++; $display("FAIL lock_model e=%0d got=%b/%h want=%b/%h", e, rd_valid, status, exp_valid, exp_status);
         end
         if (e == 16) begin
            n_checks++;
            if (status.state !== 2'd1) begin
               n_fail++; $display("FAIL lock_early e=16 state got=%0d want=1", status.state);
            end
         end
         if (e == 17) begin
            n_checks++;
            if (status.state !== 2'd2 || status.locked !== 1'b1 || status.lock_cycles !== 16'd14) begin
               n_fail++; $display("FAIL lock_edge17 state/locked/cycles got=%0d/%b/%0d want=2/1/14",
                                  status.state, status.locked, status.lock_cycles);
            end
         end
      end
   endtask

   task automatic test_glitch();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int e = 1; e <= 16; e++) begin
         drive(1'b0, 1'b1, (e >= 5 && e <= 7) || e >= 9, 1'b1, 1'b0);
         step();
         n_checks++;
         if ({rd_valid, status} !== {exp_valid, exp_status}) begin
            n_fail++; $display("FAIL glitch_model e=%0d got=%h want=%h", e, status, exp_status);
         end
         if (e == 13) begin
            n_checks++;
            if (status.state !== 2'd1) begin
               n_fail++; $display("FAIL glitch_early state got=%0d want=1", status.state);
            end
         end
         if (e == 14) begin
            n_checks++;
            if (status.state !== 2'd2 || status.lock_cycles !== 16'd12) begin
               n_fail++; $display("FAIL glitch_lock state/cycles got=%0d/%0d want=2/12", status.state, status.lock_cycles);
            end
         end
      end
   endtask

   task automatic test_loss_clear();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int e = 1; e <= 12; e++) begin
         drive(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b1, c != 0, (c == 2) ? 1'b1 : 1'($urandom_range(0, 1)), i == 3 && c == 2);
            step();
            n_checks++;
            if ({rd_valid, status} !== {exp_valid, exp_status}) begin
               n_fail++; $display("FAIL loss_model i=%0d c=%0d got=%h want=%h", i, c, status, exp_status);
            end
            if (c == 2 && (i == 2 || i == 3)) begin
               n_checks++;
               if (status.state !== 2'd3 || status.lock_lost !== 1'b1 ||
                   status.loss_count !== ((i == 2) ? 8'd3 : 8'd1)) begin
                  n_fail++; $display("FAIL loss_count i=%0d state/lost/count got=%0d/%b/%0d want=3/1/%0d",
                                     i, status.state, status.lock_lost, status.loss_count, (i == 2) ? 3 : 1);
               end
            end
         end
      end
   endtask

   task automatic test_timeout();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int e = 1; e <= 110; e++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         step();
         n_checks++;
         if ({rd_valid, status} !== {exp_valid, exp_status}) begin
            n_fail++; $display("FAIL timeout_model e=%0d got=%h want=%h", e, status, exp_status);
         end
         if (e == 100) begin
            n_checks++;
            if (status.lock_timeout !== 1'b0) begin
               n_fail++; $display("FAIL timeout_early got=%b want=0", status.lock_timeout);
            end
         end
         if (e == 101 || e == 110) begin
            n_checks++;
            if (status.lock_timeout !== 1'b1 || status.state !== 2'd1) begin
               n_fail++; $display("FAIL timeout_set e=%0d to/state got=%b/%0d want=1/1", e, status.lock_timeout, status.state);
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      n_checks++;
      if (status.state !== 2'd0 || status.lock_timeout !== 1'b1) begin
         n_fail++; $display("FAIL timeout_off state/to got=%0d/%b want=0/1", status.state, status.lock_timeout);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      n_checks++;
      if (status.lock_timeout !== 1'b0 || status.state !== 2'd0) begin
         n_fail++; $display("FAIL timeout_clr to/state got=%b/%0d want=0/0", status.lock_timeout, status.state);
      end
   endtask

   task automatic test_saturation();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int e = 1; e <= 12; e++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         step();
      end
      for (int i = 0; i < 300; i++) begin
         for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1, c != 0, $urandom_range(0, 3) == 0, 1'b0);
            step();
            n_checks++;
            if ({rd_valid, status} !== {exp_valid, exp_status}) begin
               n_fail++; $display("FAIL sat_model i=%0d c=%0d got=%h want=%h", i, c, status, exp_status);
            end
         end
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      n_checks++;
      if (status.loss_count !== 8'd255 || status.lock_lost !== 1'b1) begin
         n_fail++; $display("FAIL sat_count count/lost got=%0d/%b want=255/1", status.loss_count, status.lock_lost);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int e = 1; e <= 12; e++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         step();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, k != 1, k < 3, 1'b0);
         step();
         n_checks++;
         if (rd_valid !== (k < 3) || status !== exp_status) begin
            n_fail++; $display("FAIL b2b_valid k=%0d got=%b/%h want=%b/%h", k, rd_valid, status, k < 3, exp_status);
         end
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
         step();
         n_checks++;
         if (rd_valid !== 1'b1 || status !== exp_status) begin
            n_fail++; $display("FAIL b2b_second k=%0d got=%b/%h want=1/%h", k, rd_valid, status, exp_status);
         end
      end
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      n_checks++;
      if (rd_valid !== 1'b0 || status !== '0) begin
         n_fail++; $display("FAIL b2b_reset got=%b/%h want=0/0", rd_valid, status);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      n_checks++;
      if ({rd_valid, status} !== {exp_valid, exp_status}) begin
         n_fail++; $display("FAIL b2b_after got=%b/%h want=%b/%h", rd_valid, status, exp_valid, exp_status);
      end
   endtask

   task automatic test_random();
      logic lk, pe;
      lk = 1'b0;
      pe = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) == 0)  lk = ~lk;
         if ($urandom_range(0, 49) == 0) pe = ~pe;
         drive($urandom_range(0, 299) == 0, pe, lk, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
         step();
         n_checks++;
         if ({rd_valid, status} !== {exp_valid, exp_status}) begin
            n_fail++; $display("FAIL random_model n=%0d got=%b/%h want=%b/%h", n, rd_valid, status, exp_valid, exp_status);
         end
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_lock();
      test_glitch();
      test_loss_clear();
      test_timeout();
      test_saturation();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
